// File: rtl/bram_rd_responder_if.sv
// Client request/response and BRAM read-port signals of bram_rd_responder.
// slave is the responder's view; master is the client plus BRAM side.
interface bram_rd_responder_if #(
  parameter int ADDR_W = 13
);
  logic              i_bram_rd_addr_ready;
  logic              i_bram_access_type;
  logic [ADDR_W-1:0] i_bram_rd_addr;
  logic              o_bram_data_valid;
  logic [511:0]      o_bram_data;
  logic              o_busy;
  logic              o_bram_en;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [31:0]       i_bram_dout;

  modport slave (
    input  i_bram_rd_addr_ready, i_bram_access_type, i_bram_rd_addr, i_bram_dout,
    output o_bram_data_valid, o_bram_data, o_busy, o_bram_en, o_bram_addr
  );

  modport master (
    output i_bram_rd_addr_ready, i_bram_access_type, i_bram_rd_addr, i_bram_dout,
    input  o_bram_data_valid, o_bram_data, o_busy, o_bram_en, o_bram_addr
  );
endinterface

// File: rtl/bram_rd_responder.sv
// BRAM read responder: 32-bit single reads, plus 16-word 512-bit bursts when
// built with BRAM_RD_512B_EN defined (otherwise every request is a 32-bit read).
module bram_rd_responder #(
  parameter int ADDR_W     = 13,
  parameter int RD_LATENCY = 2
) (
  input logic                 i_clk,
  input logic                 i_rstn,
  bram_rd_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic                  rearm;
  logic                  burst;
  logic                  en_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0]            issue_cnt;
  logic [3:0]            cap_cnt;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic                  last_issue;
  logic                  last_cap;

`ifdef BRAM_RD_512B_EN
  logic [511:0] data_q;
  logic         burst_q;

  assign burst           = burst_q;
  assign bus.o_bram_data = data_q;
`else
  logic [31:0] data_q;

  assign burst           = 1'b0;
  assign bus.o_bram_data = {480'd0, data_q};
`endif

  assign last_issue = !burst || (issue_cnt == 4'hF);
  assign last_cap   = !burst || (cap_cnt == 4'hF);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      rearm     <= 1'b1;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      vld_pipe  <= '0;
      data_q    <= '0;
`ifdef BRAM_RD_512B_EN
      burst_q   <= 1'b0;
`endif
    end else begin
      // A request must be seen low at least once before it can be accepted again.
      if (!bus.i_bram_rd_addr_ready)
        rearm <= 1'b1;

      vld_pipe[0] <= en_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++)
        vld_pipe[i] <= vld_pipe[i-1];

      if (vld_pipe[RD_LATENCY-1]) begin
`ifdef BRAM_RD_512B_EN
        data_q[{cap_cnt, 5'd0} +: 32] <= bus.i_bram_dout;
`else
        data_q <= bus.i_bram_dout;
`endif
        cap_cnt <= cap_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (bus.i_bram_rd_addr_ready && rearm) begin
            rearm     <= 1'b0;
            state     <= ISSUE;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            data_q    <= '0;
`ifdef BRAM_RD_512B_EN
            burst_q   <= !bus.i_bram_access_type;
            addr_q    <= bus.i_bram_access_type ? bus.i_bram_rd_addr
                                                : {bus.i_bram_rd_addr[ADDR_W-1:4], 4'd0};
`else
            addr_q    <= bus.i_bram_rd_addr;
`endif
          end
        end
        ISSUE: begin
          if (last_issue) begin
            en_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            addr_q    <= addr_q + 1'b1;
            issue_cnt <= issue_cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (vld_pipe[RD_LATENCY-1] && last_cap) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_bram_en         = en_q;
  assign bus.o_bram_addr       = addr_q;
  assign bus.o_bram_data_valid = valid_q;
  assign bus.o_busy            = busy_q;

endmodule

// File: tb/tb_bram_rd_responder.sv
// Scoreboard bench for bram_rd_responder: a driver queues expected BRAM
// addresses and read results, negedge monitors pop and compare them.
module tb_bram_rd_responder;

  localparam int RD_LATENCY = 2;

  typedef struct {
    logic [511:0] data;
    int           vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  int   n_exp_valid = 0;

  exp_t        exp_q[$];
  logic [12:0] exp_addr_q[$];
  logic [31:0] rd_pipe [3];

  bram_rd_responder_if #(.ADDR_W(13)) bus ();

  bram_rd_responder #(.ADDR_W(13), .RD_LATENCY(RD_LATENCY)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [12:0] a);
    return (a == 13'h0005) ? 32'hDEADBEEF : {19'd0, a};
  endfunction

  // BRAM model: dout appears RD_LATENCY cycles after the enable cycle.
  always @(posedge clk) begin
    if (bus.o_bram_en) rd_pipe[0] <= mem_val(bus.o_bram_addr);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.i_bram_dout = rd_pipe[RD_LATENCY-1];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: got event at cycle %0d want none", name, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.o_bram_en) begin
      if (exp_addr_q.size() == 0) unexpected("bram_en");
      else check("bram_addr", bus.o_bram_addr, exp_addr_q.pop_front());
    end
    if (bus.o_bram_data_valid) begin
      exp_t e;
      n_valid++;
      if (exp_q.size() == 0) unexpected("data_valid");
      else begin
        e = exp_q.pop_front();
        check("rd_data", bus.o_bram_data, e.data);
        check("valid_cycle", cyc, e.vcyc);
      end
    end
  end

  task automatic do_read(input logic [12:0] a, input logic t, input int hold);
    exp_t        e;
    logic        is_burst;
    logic [12:0] base;
    int          e0;
    int          got;
    @(negedge clk);
    bus.i_bram_rd_addr_ready = 1'b1;
    bus.i_bram_rd_addr       = a;
    bus.i_bram_access_type   = t;
`ifdef BRAM_RD_512B_EN
    is_burst = !t;
`else
    is_burst = 1'b0;
`endif
    e0 = cyc + 1;
    e.data = '0;
    // valid rises on edge E0+L+1 (single) or E0+L+16 (burst)
    if (is_burst) begin
      base = {a[12:4], 4'h0};
      for (int k = 0; k < 16; k++) begin
        exp_addr_q.push_back(base + 13'(k));
        e.data[32*k +: 32] = mem_val(base + 13'(k));
      end
      e.vcyc = e0 + RD_LATENCY + 16;
    end else begin
      exp_addr_q.push_back(a);
      e.data[31:0] = mem_val(a);
      e.vcyc = e0 + RD_LATENCY + 1;
    end
    exp_q.push_back(e);
    n_exp_valid++;
    @(negedge clk);
    check("busy_after_accept", bus.o_busy, 1);
    bus.i_bram_rd_addr     = a ^ 13'h0AAA;
    bus.i_bram_access_type = ~t;
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      if (bus.o_bram_data_valid) got = 1;
      else @(negedge clk);
    end
    check("valid_seen", got, 1);
    @(negedge clk);
    check("data_hold", bus.o_bram_data, e.data);
    check("busy_idle", bus.o_busy, 0);
    repeat (hold) @(negedge clk);
    bus.i_bram_rd_addr_ready = 1'b0;
  endtask

  task automatic reset_mid(input logic [12:0] a, input logic t, input int words);
    int e0;
    int got;
    int v0;
    @(negedge clk);
    bus.i_bram_rd_addr_ready = 1'b1;
    bus.i_bram_rd_addr       = a;
    bus.i_bram_access_type   = t;
    e0 = cyc + 1;
    for (int k = 0; k < words; k++) exp_addr_q.push_back(a + 13'(k));
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      @(negedge clk);
      if (cyc == e0 + words - 1) got = 1;
    end
    check("reset_point_reached", got, 1);
    v0 = n_valid;
    #2;
    rst_n = 1'b0;
    bus.i_bram_rd_addr_ready = 1'b0;
    #1;
    check("rst_mid_en", bus.o_bram_en, 0);
    check("rst_mid_valid", bus.o_bram_data_valid, 0);
    check("rst_mid_busy", bus.o_busy, 0);
    check("rst_mid_addr", bus.o_bram_addr, 0);
    check("rst_mid_data", bus.o_bram_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_valid_after_reset", n_valid, v0);
    check("addr_queue_after_reset", exp_addr_q.size(), 0);
  endtask

  initial begin
    bus.i_bram_rd_addr_ready = 1'b0;
    bus.i_bram_access_type   = 1'b1;
    bus.i_bram_rd_addr       = '0;
    repeat (3) @(negedge clk);
    check("reset_en", bus.o_bram_en, 0);
    check("reset_valid", bus.o_bram_data_valid, 0);
    check("reset_busy", bus.o_busy, 0);
    check("reset_addr", bus.o_bram_addr, 0);
    check("reset_data", bus.o_bram_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_read(13'h0005, 1'b1, 0);
`ifdef BRAM_RD_512B_EN
    do_read(13'h0013, 1'b0, 0);
    do_read(13'h1FF0, 1'b0, 0);
`else
    do_read(13'h0013, 1'b0, 0);
`endif
    do_read(13'h0021, 1'b1, 3);
    do_read(13'h0022, 1'b1, 0);
`ifdef BRAM_RD_512B_EN
    reset_mid(13'h0040, 1'b0, 8);
`else
    reset_mid(13'h0009, 1'b1, 1);
`endif
    do_read(13'h0007, 1'b1, 0);
    repeat (5) @(negedge clk);

    check("valid_count", n_valid, n_exp_valid);
    check("exp_queue_empty", exp_q.size(), 0);
    check("addr_queue_empty", exp_addr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
